// File: rtl/mem_port_arbiter_if.sv
// Bus bundles for the memory port arbiter.
// mem_port_arbiter_if : N requesting masters on one side, the arbiter on the other.
// mem_bus_if          : single downstream memory port, arbiter to memory controller.
interface mem_port_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64
);
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS*2-1:0]      m_datasize;
  logic [NUM_MASTERS-1:0]        m_read;
  logic [NUM_MASTERS-1:0]        m_write;
  logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0]             m_readdata;
  logic [NUM_MASTERS-1:0]        m_done;

  // Requesting side (fetch, exec, trap sequencer, debug port)
  modport master (
    output m_address, m_datasize, m_read, m_write, m_writedata,
    input  m_readdata, m_done
  );

  // Arbiter side
  modport slave (
    input  m_address, m_datasize, m_read, m_write, m_writedata,
    output m_readdata, m_done
  );
endinterface

interface mem_bus_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_datasize;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_done;

  // Arbiter drives the downstream request
  modport master (
    output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_done
  );

  // Memory controller answers
  modport slave (
    input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_done
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for the single CPU memory port.
// One transaction at a time: IDLE picks a winner and latches its request,
// BUSY drives the latched request downstream until mem_done, HOLDOFF burns
// one cycle so a master's request that is still high right after its done
// is never granted a second time.
module mem_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int RR_MODE     = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mem_port_arbiter_if.slave      up,
  mem_bus_if.master              mem,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   proto_err
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic [1:0]             datasize_q, datasize_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic [DATA_W-1:0]      writedata_q, writedata_d;
  logic                   proto_err_q, proto_err_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;

  assign req = up.m_read | up.m_write;

  // Winner search: lowest index, or first requester after last_grant when round-robin.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest requester wins.
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        int idx;
        idx = (int'(last_grant_q) + k) % NUM_MASTERS;
        if (req[idx]) begin
          win_vld = 1'b1;
          win_idx = IDX_W'(idx);
        end
      end
    end
  end

  // Next-state logic: transaction sequencing and request latching.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    datasize_d   = datasize_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    // Any master driving read and write together is a protocol violation.
    proto_err_d  = proto_err_q | (|(up.m_read & up.m_write));

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d      = BUSY;
          grant_d      = NUM_MASTERS'(1) << win_idx;
          last_grant_d = win_idx;
          address_d    = up.m_address[win_idx*ADDR_W +: ADDR_W];
          datasize_d   = up.m_datasize[win_idx*2 +: 2];
          writedata_d  = up.m_writedata[win_idx*DATA_W +: DATA_W];
          read_d       = up.m_read[win_idx];
          // A read+write request is forwarded as the read only.
          write_d      = up.m_write[win_idx] & ~up.m_read[win_idx];
        end
      end
      BUSY: begin
        if (mem.mem_done) begin
          state_d = HOLDOFF;
          grant_d = '0;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      address_q    <= '0;
      datasize_q   <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      datasize_q   <= datasize_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign mem.mem_address   = address_q;
  assign mem.mem_datasize  = datasize_q;
  assign mem.mem_read      = read_q;
  assign mem.mem_write     = write_q;
  assign mem.mem_writedata = writedata_q;

  // Completion goes only to the owner, and only while a transaction is open.
  assign up.m_done     = (state_q == BUSY && mem.mem_done) ? grant_q : '0;
  assign up.m_readdata = mem.mem_readdata;

  assign grant     = grant_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-master fixed-priority instance
// and a 3-master round-robin instance share clock and reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(64), .DATA_W(64)) up0 ();
  mem_bus_if          #(.ADDR_W(64), .DATA_W(64))                  mb0 ();
  logic [1:0] grant0;
  logic       perr0;

  mem_port_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(64), .DATA_W(64)) up1 ();
  mem_bus_if          #(.ADDR_W(64), .DATA_W(64))                  mb1 ();
  logic [2:0] grant1;
  logic       perr1;

  mem_port_arbiter #(.NUM_MASTERS(2), .ADDR_W(64), .DATA_W(64), .RR_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .up(up0), .mem(mb0), .grant(grant0), .proto_err(perr0)
  );

  mem_port_arbiter #(.NUM_MASTERS(3), .ADDR_W(64), .DATA_W(64), .RR_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .up(up1), .mem(mb1), .grant(grant1), .proto_err(perr1)
  );

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp [4];
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    up0.m_address = '0; up0.m_datasize = '0; up0.m_read = '0; up0.m_write = '0; up0.m_writedata = '0;
    up1.m_address = '0; up1.m_datasize = '0; up1.m_read = '0; up1.m_write = '0; up1.m_writedata = '0;
    mb0.mem_readdata = '0; mb0.mem_done = 1'b0;
    mb1.mem_readdata = '0; mb1.mem_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_grant0", 64'(grant0), 64'h0);
    chk("rst_mem_read", 64'(mb0.mem_read), 64'h0);
    chk("rst_mem_write", 64'(mb0.mem_write), 64'h0);
    chk("rst_mem_address", mb0.mem_address, 64'h0);
    chk("rst_proto_err", 64'(perr0), 64'h0);
    chk("rst_m_done", 64'(up0.m_done), 64'h0);
    chk("rst_grant1", 64'(grant1), 64'h0);
    reset_n = 1'b1;

    // Single read by master 0, 3-cycle memory latency
    tick();
    up0.m_read = 2'b01;
    up0.m_address[63:0] = 64'h8000fffffffffffc;
    up0.m_datasize[1:0] = 2'd2;
    #1;
    chk("t1_idle_grant", 64'(grant0), 64'h0);
    chk("t1_idle_mem_read", 64'(mb0.mem_read), 64'h0);
    tick();
    chk("t1_c1_mem_read", 64'(mb0.mem_read), 64'h1);
    chk("t1_c1_grant", 64'(grant0), 64'h1);
    chk("t1_c1_address", mb0.mem_address, 64'h8000fffffffffffc);
    chk("t1_c1_datasize", 64'(mb0.mem_datasize), 64'h2);
    tick();
    tick();
    chk("t1_c3_mem_read", 64'(mb0.mem_read), 64'h1);
    chk("t1_c3_no_done", 64'(up0.m_done), 64'h0);
    mb0.mem_done = 1'b1;
    mb0.mem_readdata = 64'h1234;
    #1;
    chk("t1_done", 64'(up0.m_done), 64'h1);
    chk("t1_readdata", up0.m_readdata, 64'h1234);
    chk("t1_done_mem_read", 64'(mb0.mem_read), 64'h1);
    // HOLDOFF: stray mem_done and a still-high request must be ignored
    tick();
    chk("t1_hold_grant", 64'(grant0), 64'h0);
    chk("t1_hold_mem_read", 64'(mb0.mem_read), 64'h0);
    chk("t1_hold_no_done", 64'(up0.m_done), 64'h0);
    mb0.mem_done = 1'b0;
    tick();
    up0.m_read = 2'b00;
    #1;
    chk("t1_idle_after_hold", 64'(grant0), 64'h0);
    chk("t1_no_regrant_read", 64'(mb0.mem_read), 64'h0);
    tick();
    chk("t1_still_idle", 64'(grant0), 64'h0);

    // Fixed priority: master 1 starves while master 0 keeps requesting
    up0.m_read = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("t2_grant_%0d", n), 64'(grant0), 64'h1);
      mb0.mem_done = 1'b1;
      #1;
      chk($sformatf("t2_done_%0d", n), 64'(up0.m_done), 64'h1);
      tick();
      mb0.mem_done = 1'b0;
      tick();
    end
    up0.m_read = 2'b00;
    tick();

    // Round robin over three masters
    up1.m_read = 3'b111;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk($sformatf("t3_rr_grant_%0d", n), 64'(grant1), 64'(rr_exp[n]));
      mb1.mem_done = 1'b1;
      #1;
      chk($sformatf("t3_rr_done_%0d", n), 64'(up1.m_done), 64'(rr_exp[n]));
      tick();
      mb1.mem_done = 1'b0;
      tick();
    end
    up1.m_read = 3'b000;
    tick();

    // Master 1 write; inputs change mid-transaction
    up0.m_write = 2'b10;
    up0.m_address[127:64] = 64'h100;
    up0.m_datasize[3:2] = 2'd3;
    up0.m_writedata[127:64] = 64'hdeadbeef;
    tick();
    chk("t4_grant", 64'(grant0), 64'h2);
    chk("t4_mem_write", 64'(mb0.mem_write), 64'h1);
    chk("t4_mem_read", 64'(mb0.mem_read), 64'h0);
    chk("t4_wdata", mb0.mem_writedata, 64'hdeadbeef);
    up0.m_writedata[127:64] = 64'h0;
    up0.m_write = 2'b00;
    tick();
    chk("t4_wdata_held", mb0.mem_writedata, 64'hdeadbeef);
    chk("t4_write_held", 64'(mb0.mem_write), 64'h1);
    chk("t4_addr_held", mb0.mem_address, 64'h100);
    mb0.mem_done = 1'b1;
    #1;
    chk("t4_done", 64'(up0.m_done), 64'h2);
    tick();
    mb0.mem_done = 1'b0;
    #1;
    chk("t4_write_off", 64'(mb0.mem_write), 64'h0);
    tick();

    // Read and write together from one master
    up0.m_read = 2'b01;
    up0.m_write = 2'b01;
    tick();
    chk("t5_proto_err", 64'(perr0), 64'h1);
    chk("t5_mem_read", 64'(mb0.mem_read), 64'h1);
    chk("t5_mem_write", 64'(mb0.mem_write), 64'h0);
    up0.m_read = 2'b00;
    up0.m_write = 2'b00;
    mb0.mem_done = 1'b1;
    tick();
    mb0.mem_done = 1'b0;
    tick();
    tick();
    chk("t5_proto_err_sticky", 64'(perr0), 64'h1);

    // Asynchronous reset while BUSY
    up0.m_read = 2'b01;
    up0.m_address[63:0] = 64'h40;
    tick();
    chk("t6_busy_read", 64'(mb0.mem_read), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_read", 64'(mb0.mem_read), 64'h0);
    chk("t6_rst_grant", 64'(grant0), 64'h0);
    chk("t6_rst_address", mb0.mem_address, 64'h0);
    chk("t6_rst_proto_err", 64'(perr0), 64'h0);
    up0.m_read = 2'b00;
    tick();
    reset_n = 1'b1;
    mb0.mem_done = 1'b1;
    #1;
    chk("t6_late_done", 64'(up0.m_done), 64'h0);
    tick();
    mb0.mem_done = 1'b0;
    #1;
    chk("t6_idle_grant", 64'(grant0), 64'h0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
